// File: rtl/sha_digest_to_scalar_if.sv
// Handshake bundle between the SHA-256 stage, the digest-to-scalar converter
// and the ECDSA datapath that consumes the reduced scalar z.
interface sha_digest_to_scalar_if #(
  parameter int N_BITS = 256
);
  logic [255:0]      hashed;
  logic              hash_done;
  logic [N_BITS-1:0] z;
  logic              z_valid;
  logic              z_ready;
  logic              busy;
  logic              overrun;

  // Producer/consumer side: supplies the digest and accepts z.
  modport master (
    output hashed, hash_done, z_ready,
    input  z, z_valid, busy, overrun
  );

  // Converter side.
  modport slave (
    input  hashed, hash_done, z_ready,
    output z, z_valid, busy, overrun
  );
endinterface

// File: rtl/sha_digest_to_scalar.sv
// Converts a SHA-256 digest into the ECDSA scalar z: keeps the leftmost N_BITS
// bits, then reduces once modulo ORDER using a limb-serial subtractor
// (one LIMB-wide limb per cycle, least significant limb first). The result is
// held under a valid/ready handshake; digests arriving while busy are dropped
// and flagged with a one-cycle overrun pulse.
module sha_digest_to_scalar #(
  parameter int                N_BITS = 256,
  parameter int                LIMB   = 32,
  parameter logic [N_BITS-1:0] ORDER  =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141
) (
  input  logic                    clk,
  input  logic                    rst,
  sha_digest_to_scalar_if.slave   bus
);

  localparam int NL = N_BITS / LIMB;
  localparam int IW = (NL > 1) ? $clog2(NL) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    SEL,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic              done_q;
  logic              start;
  logic [IW-1:0]     idx;
  logic              borrow;
  logic              last_limb;
  logic [N_BITS-1:0] e_q;
  logic [N_BITS-1:0] d_q;
  logic [LIMB:0]     diff;

  // Rising edge of the level done flag. done_q comes out of reset at 1 so a
  // digest still flagged done across reset is not mistaken for a new one.
  assign start     = bus.hash_done & ~done_q;
  assign last_limb = (idx == IW'(NL - 1));

  // One limb of e - ORDER with incoming borrow; bit LIMB is the outgoing borrow.
  always_comb begin
    diff = {1'b0, e_q[idx*LIMB +: LIMB]}
         - {1'b0, ORDER[idx*LIMB +: LIMB]}
         - {{LIMB{1'b0}}, borrow};
  end

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start)       state_d = SUB;
      SUB:  if (last_limb)   state_d = SEL;
      SEL:                   state_d = HOLD;
      HOLD: if (bus.z_ready) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  // NOTE: the operand and difference registers are reset along with control so
  // an aborted subtraction leaves no stale limbs behind; they are flops, not
  // RAM, so the reset costs nothing structural.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q      <= 1'b1;
      e_q         <= '0;
      d_q         <= '0;
      idx         <= '0;
      borrow      <= 1'b0;
      bus.z       <= '0;
      bus.z_valid <= 1'b0;
      bus.busy    <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      done_q      <= bus.hash_done;
      // Any start outside IDLE (including the HOLD->IDLE handoff cycle) drops.
      bus.overrun <= start && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            e_q      <= bus.hashed[255 -: N_BITS];
            idx      <= '0;
            borrow   <= 1'b0;
            bus.busy <= 1'b1;
          end
        end
        SUB: begin
          d_q[idx*LIMB +: LIMB] <= diff[LIMB-1:0];
          borrow                <= diff[LIMB];
          idx                   <= idx + IW'(1);
        end
        SEL: begin
          // A final borrow means e < ORDER, so e is already reduced.
          bus.z       <= borrow ? e_q : d_q;
          bus.z_valid <= 1'b1;
          bus.busy    <= 1'b0;
        end
        HOLD: begin
          if (bus.z_ready) bus.z_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
